shift_register_univ: RTL and testbench
======================================

// Module: shift_register_univ
// PURPOSE
//  Parametrised universal shift register: generalises the plain enabled D register
//  with hold/load/shift-left/shift-right modes, serial in/out and a shift counter.
//  It is the shared datapath core for the UART TX/RX serialisers:
//   - TX: parallel load, then shift out.
//   - RX: shift in, then read q in parallel.
//  The done pulse marks that a full word has been shifted.
// PARAMETERS
//  D_BIT    8   register width in bits, >= 2
//  RST_VAL  0   value q takes on reset, D_BIT wide
//  CNT_W    $clog2(D_BIT+1)  localparam, width of cnt
// PORTS
//  clk    in   1       clock, all state updates on rising edge
//  rst    in   1       reset: synchronous, active-high
//  en     in   1       clock enable for q/cnt/par updates
//  mode   in   2       00 hold, 01 shift right, 10 shift left, 11 parallel load
//  d      in   D_BIT   parallel load data
//  sin    in   1       serial input bit
//  q      out  D_BIT   register contents
//  sout   out  1       serial output, combinational: mode==10 ? q[D_BIT-1] : q[0]
//  cnt    out  CNT_W   shifts since last load/reset, saturates at D_BIT
//  done   out  1       registered 1-cycle pulse on completion of the D_BIT-th shift
// BEHAVIOUR
//  - Reset:
//     - rst=1 at an edge: q<=RST_VAL, cnt<=0, done<=0, par<=0.
//     - rst has priority over en and mode.
//     - A reset mid-word aborts the word; no done pulse is produced.
//  - en=0: q, cnt and par hold. done<=0.
//  - en=1, action by mode:
//     - 00 (hold): q and cnt hold, done<=0.
//     - 11 (load): q<=d, cnt<=0, done<=0, par<=0.
//     - 01 (shift right): q<={sin, q[D_BIT-1:1]}. The bit leaving is q[0] (= sout).
//     - 10 (shift left): q<={q[D_BIT-2:0], sin}. The bit leaving is q[D_BIT-1] (= sout).
//  - Counter (shift modes only):
//     - If cnt<D_BIT, cnt<=cnt+1.
//     - If cnt==D_BIT, cnt stays at D_BIT (saturate; no wrap). q still shifts.
//  - done:
//     - done<=1 only on the shift that moves cnt from D_BIT-1 to D_BIT.
//     - Otherwise done<=0, giving exactly one pulse per word.
//     - Shifts after saturation give no further pulse until a load or reset.
//  - Word state, implied by cnt:
//     - EMPTY (cnt==0) -> SHIFTING (0<cnt<D_BIT) -> FULL (cnt==D_BIT).
//     - Load or reset returns to EMPTY from any state.
//  - Latency: q, cnt and done are visible 1 cycle after the qualifying edge.
//    sout follows q and mode with zero latency.
//  - Mixing left and right shifts within a word is legal. Each shift counts once.
// CONFIGURATION
//  - SHREG_PARITY_EN defined:
//     - Adds output port par (out, 1): running XOR of all bits shifted out since
//       the last load/reset.
//     - On each en=1 shift: par<=par^sout (sout is the pre-shift value).
//     - Cleared by load and reset. Holds otherwise.
//  - SHREG_PARITY_EN undefined: port par and its logic are absent. All other
//    behaviour is identical.
// TESTING  (D_BIT=8, RST_VAL=0)
//  1. Reset priority: rst=1, en=1, mode=11, d=8'hA5 for 1 edge
//     -> q=8'h00, cnt=0, done=0.
//  2. Shift right: load 8'hA5, then 8 shift-right edges with sin=0
//     -> sout=1,0,1,0,0,1,0,1 (one bit per shift)
//     -> final q=8'h00, cnt=8
//     -> done=1 for exactly the cycle after the 8th shift.
//  3. Shift left: load 8'h0F, then 4 shift-left edges with sin=0
//     -> q=1E,3C,78,F0; sout=0 throughout; cnt=4; done=0.
//  4. Enable gating: en=0, mode=01, toggle sin for 5 cycles
//     -> q and cnt unchanged; done=0.
//  5. Saturation: after test 2, a 9th shift
//     -> cnt stays 8, no done pulse.
//     Then load 8'h3C -> cnt=0.
//  6. Parity (SHREG_PARITY_EN):
//     - Load 8'hA5, 8 shift-right edges -> par=0.
//     - Load 8'h07, 8 shift-right edges -> par=1.
//     - Reset mid-word -> par=0.

Source files
------------

// File: rtl/shift_register_univ.sv
// Universal shift register: hold / shift-right / shift-left / parallel load, serial I/O,
// saturating shift counter and word-done pulse. Define SHREG_PARITY_EN to add the par output.
module shift_register_univ #(
    parameter int               D_BIT   = 8,
    parameter logic [D_BIT-1:0] RST_VAL = '0,
    localparam int              CNT_W   = $clog2(D_BIT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [D_BIT-1:0] d,
    input  logic             sin,
    output logic [D_BIT-1:0] q,
    output logic             sout,
`ifdef SHREG_PARITY_EN
    output logic             par,
`endif
    output logic [CNT_W-1:0] cnt,
    output logic             done
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(D_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(D_BIT - 1);

    logic shift_p0;
    logic load_p0;

    // The bit about to leave the register depends on the direction currently selected.
    always_comb begin
        sout = (mode == MODE_LEFT) ? q[D_BIT-1] : q[0];
    end

    always_comb begin
        shift_p0 = en && ((mode == MODE_RIGHT) || (mode == MODE_LEFT));
        load_p0  = en && (mode == MODE_LOAD);
    end

    // Register stage: data, counter and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            q    <= RST_VAL;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load_p0) begin
                q   <= d;
                cnt <= '0;
            end else if (shift_p0) begin
                if (mode == MODE_RIGHT) begin
                    q <= {sin, q[D_BIT-1:1]};
                end else begin
                    q <= {q[D_BIT-2:0], sin};
                end
                // Counter saturates so a word completes exactly once until the next load.
                if (cnt < CNT_FULL) begin
                    cnt <= cnt + CNT_W'(1);
                end
                done <= (cnt == CNT_LAST);
            end
        end
    end

`ifdef SHREG_PARITY_EN
    // Running parity of every bit shifted out since the last load or reset
    always_ff @(posedge clk) begin
        if (rst || load_p0) begin
            par <= 1'b0;
        end else if (shift_p0) begin
            par <= par ^ sout;
        end
    end
`endif

endmodule

// File: tb/tb_shift_register_univ.sv
// Scoreboard bench for shift_register_univ (D_BIT=8, RST_VAL=0): the stimulus queues
// hand-computed expectations; a monitor pops and compares once per clock.
module tb_shift_register_univ;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] d = 8'h00;
    logic       sin = 1'b0;
    logic [7:0] q;
    logic       sout;
    logic [3:0] cnt;
    logic       done;
`ifdef SHREG_PARITY_EN
    logic       par;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         id;
        logic       chk_sout;
        logic       sout;
        logic [7:0] q;
        logic [3:0] cnt;
        logic       done;
        logic       par;
    } exp_t;

    exp_t sb[$];
    int   step_id = 0;

    shift_register_univ #(.D_BIT(8), .RST_VAL(8'h00)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .d    (d),
        .sin  (sin),
        .q    (q),
        .sout (sout),
`ifdef SHREG_PARITY_EN
        .par  (par),
`endif
        .cnt  (cnt),
        .done (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int id, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
        end
    endtask

    // Drive one cycle of inputs and queue the expected pre-edge sout and post-edge state.
    task automatic step(input logic r, input logic e, input logic [1:0] m, input logic [7:0] dd,
                        input logic s, input logic cs, input logic xs, input logic [7:0] eq,
                        input logic [3:0] ec, input logic ed, input logic ep);
        exp_t x;
        @(posedge clk);
        #2;
        rst  = r;
        en   = e;
        mode = m;
        d    = dd;
        sin  = s;
        step_id++;
        x.id = step_id; x.chk_sout = cs; x.sout = xs;
        x.q = eq; x.cnt = ec; x.done = ed; x.par = ep;
        sb.push_back(x);
    endtask

    // Monitor: sout is sampled mid-cycle (pre-edge), state just after the edge.
    initial begin
        logic sout_pre;
        exp_t x;
        forever begin
            @(negedge clk);
            sout_pre = sout;
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                if (x.chk_sout) chk("sout", x.id, {7'd0, sout_pre}, {7'd0, x.sout});
                chk("q", x.id, q, x.q);
                chk("cnt", x.id, {4'd0, cnt}, {4'd0, x.cnt});
                chk("done", x.id, {7'd0, done}, {7'd0, x.done});
`ifdef SHREG_PARITY_EN
                chk("par", x.id, {7'd0, par}, {7'd0, x.par});
`endif
            end
        end
    end

    initial begin
        //   rst en mode   d      sin cs  sout   q      cnt  done par
        // Reset has priority over a load
        step(1, 1, 2'b11, 8'hA5, 0, 0, 0, 8'h00, 4'd0, 0, 0);
        // Load A5, eight right shifts
        step(0, 1, 2'b11, 8'hA5, 0, 1, 0, 8'hA5, 4'd0, 0, 0);
        step(0, 1, 2'b01, 8'h00, 0, 1, 1, 8'h52, 4'd1, 0, 1);
        step(0, 1, 2'b01, 8'h00, 0, 1, 0, 8'h29, 4'd2, 0, 1);
        step(0, 1, 2'b01, 8'h00, 0, 1, 1, 8'h14, 4'd3, 0, 0);
        step(0, 1, 2'b01, 8'h00, 0, 1, 0, 8'h0A, 4'd4, 0, 0);
        step(0, 1, 2'b01, 8'h00, 0, 1, 0, 8'h05, 4'd5, 0, 0);
        step(0, 1, 2'b01, 8'h00, 0, 1, 1, 8'h02, 4'd6, 0, 1);
        step(0, 1, 2'b01, 8'h00, 0, 1, 0, 8'h01, 4'd7, 0, 1);
        step(0, 1, 2'b01, 8'h00, 0, 1, 1, 8'h00, 4'd8, 1, 0);
        // Ninth shift saturates without another pulse, then hold
        step(0, 1, 2'b01, 8'h00, 1, 1, 0, 8'h80, 4'd8, 0, 0);
        step(0, 1, 2'b00, 8'h00, 0, 1, 0, 8'h80, 4'd8, 0, 0);
        step(0, 1, 2'b11, 8'h3C, 0, 1, 0, 8'h3C, 4'd0, 0, 0);
        // Load 0F, four left shifts
        step(0, 1, 2'b11, 8'h0F, 0, 1, 0, 8'h0F, 4'd0, 0, 0);
        step(0, 1, 2'b10, 8'h00, 0, 1, 0, 8'h1E, 4'd1, 0, 0);
        step(0, 1, 2'b10, 8'h00, 0, 1, 0, 8'h3C, 4'd2, 0, 0);
        step(0, 1, 2'b10, 8'h00, 0, 1, 0, 8'h78, 4'd3, 0, 0);
        step(0, 1, 2'b10, 8'h00, 0, 1, 0, 8'hF0, 4'd4, 0, 0);
        // Enable low: nothing moves
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 2'b01, 8'h00, logic'(i[0]), 1, 0, 8'hF0, 4'd4, 0, 0);
        end
        step(0, 0, 2'b11, 8'hFF, 0, 0, 0, 8'hF0, 4'd4, 0, 0);
        // Finish the word with left shifts, sin=1
        step(0, 1, 2'b10, 8'h00, 1, 1, 1, 8'hE1, 4'd5, 0, 1);
        step(0, 1, 2'b10, 8'h00, 1, 1, 1, 8'hC3, 4'd6, 0, 0);
        step(0, 1, 2'b10, 8'h00, 1, 1, 1, 8'h87, 4'd7, 0, 1);
        step(0, 1, 2'b10, 8'h00, 1, 1, 1, 8'h0F, 4'd8, 1, 0);
        // Load 07, eight right shifts: odd parity
        step(0, 1, 2'b11, 8'h07, 0, 1, 1, 8'h07, 4'd0, 0, 0);
        step(0, 1, 2'b01, 8'h00, 0, 1, 1, 8'h03, 4'd1, 0, 1);
        step(0, 1, 2'b01, 8'h00, 0, 1, 1, 8'h01, 4'd2, 0, 0);
        step(0, 1, 2'b01, 8'h00, 0, 1, 1, 8'h00, 4'd3, 0, 1);
        step(0, 1, 2'b01, 8'h00, 0, 1, 0, 8'h00, 4'd4, 0, 1);
        step(0, 1, 2'b01, 8'h00, 0, 1, 0, 8'h00, 4'd5, 0, 1);
        step(0, 1, 2'b01, 8'h00, 0, 1, 0, 8'h00, 4'd6, 0, 1);
        step(0, 1, 2'b01, 8'h00, 0, 1, 0, 8'h00, 4'd7, 0, 1);
        step(0, 1, 2'b01, 8'h00, 0, 1, 0, 8'h00, 4'd8, 1, 1);
        // Reset mid-word aborts it: no pulse when the old word would have completed
        step(0, 1, 2'b11, 8'hA5, 0, 1, 0, 8'hA5, 4'd0, 0, 0);
        step(0, 1, 2'b01, 8'h00, 1, 1, 1, 8'hD2, 4'd1, 0, 1);
        step(0, 1, 2'b01, 8'h00, 1, 1, 0, 8'hE9, 4'd2, 0, 1);
        step(1, 1, 2'b01, 8'h00, 0, 1, 1, 8'h00, 4'd0, 0, 0);
        step(0, 1, 2'b01, 8'h00, 0, 1, 0, 8'h00, 4'd1, 0, 0);
        step(0, 1, 2'b01, 8'h00, 0, 1, 0, 8'h00, 4'd2, 0, 0);
        step(0, 1, 2'b01, 8'h00, 0, 1, 0, 8'h00, 4'd3, 0, 0);
        step(0, 1, 2'b01, 8'h00, 0, 1, 0, 8'h00, 4'd4, 0, 0);
        step(0, 1, 2'b01, 8'h00, 0, 1, 0, 8'h00, 4'd5, 0, 0);
        step(0, 1, 2'b01, 8'h00, 0, 1, 0, 8'h00, 4'd6, 0, 0);
        step(0, 0, 2'b00, 8'h00, 0, 1, 0, 8'h00, 4'd6, 0, 0);

        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
